// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared types and constants for the CPU-side SRAM arbiter.
//   owner_e      : which requester owns the access currently in flight
//   arb_state_e  : arbiter FSM state (IDLE = nothing outstanding, BUSY = one access outstanding)
//   MEM_LAT_MAX  : largest supported SRAM completion latency
//   CNT_W        : width of the latency down-counter (must hold MEM_LAT_MAX)
//   STARVE_W     : width of the fetch-starvation counter
//   sat_inc      : saturating increment used by the starvation counter
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 3;
  localparam int STARVE_W    = 4;

  // Increment v, but never beyond lim.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// cpu_sram_arbiter_if
//   Bundles the fetch port, the load/store port and the SRAM port of the
//   arbiter.
//   slave  : the arbiter's view (takes requests, drives acceptance/responses and SRAM controls)
//   master : the environment's view (CPU pipeline stages plus the SRAM model)
//
//   Handshake: a requester raises *_req with a stable payload and holds both
//   until *_addr_ok is seen high in the same cycle; that cycle is the
//   transfer. Dropping *_req before *_addr_ok withdraws the request and
//   nothing is remembered. *_data_ok is a one-cycle pulse MEM_LAT cycles
//   after the transfer and carries *_rdata; it cannot be back-pressured.
interface cpu_sram_arbiter_if;
  // fetch port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // load/store port
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // SRAM port
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_arb_pick.sv
// cpu_arb_pick
//   Combinational two-way grant select. Data wins ties unless the fetch side
//   has been passed over STARVE_LIMIT times in a row (starve_hit).
//   inst_req, data_req : live requests
//   slot_free          : the SRAM can take a new access this cycle
//   starve_hit         : starvation counter has reached its limit
//   gnt_inst, gnt_data : one-hot (or zero) grant
module cpu_arb_pick (
  input  logic inst_req,
  input  logic data_req,
  input  logic slot_free,
  input  logic starve_hit,
  output logic gnt_inst,
  output logic gnt_data
);

  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (slot_free) begin
      if (inst_req && data_req) begin
        if (starve_hit) gnt_inst = 1'b1;
        else            gnt_data = 1'b1;
      end else if (data_req) begin
        gnt_data = 1'b1;
      end else if (inst_req) begin
        gnt_inst = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
//   Shares one single-port synchronous SRAM between instruction fetch and
//   data access. At most one access is in flight; a new one may be granted
//   in the same cycle the previous one completes, so MEM_LAT=1 streams one
//   access per cycle. Data has priority; a starvation counter forces a
//   fetch grant after STARVE_LIMIT consecutive data grants that bypassed a
//   waiting fetch.
//   Parameters: STARVE_LIMIT (1..15), MEM_LAT (1..MEM_LAT_MAX)
//   clk, resetn    : clock, asynchronous active-low reset
//   bus            : fetch / load-store / SRAM signals (cpu_sram_arbiter_if.slave)
//   dbg_state      : FSM state
//   dbg_owner      : owner of the access in flight
//   dbg_cnt        : cycles left until the in-flight access completes
//   dbg_starve_cnt : consecutive data grants while fetch was waiting
module cpu_sram_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_LAT      = 1
) (
  input  logic                clk,
  input  logic                resetn,
  cpu_sram_arbiter_if.slave   bus,
  output arb_state_e          dbg_state,
  output owner_e              dbg_owner,
  output logic [CNT_W-1:0]    dbg_cnt,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  localparam logic [CNT_W-1:0]    LAT_CNT   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic inst_req_g;
  logic data_req_g;
  logic completing;
  logic slot_free;
  logic gnt_inst;
  logic gnt_data;

  // Requests are masked while reset is held so that every output, including
  // the combinational addr_ok and mem_* paths, reads 0 during reset.
  assign inst_req_g = bus.inst_req & resetn;
  assign data_req_g = bus.data_req & resetn;

  // The in-flight access finishes this cycle, which also frees the slot for
  // a back-to-back grant.
  assign completing = (state_q == ARB_BUSY) && (cnt_q == CNT_ONE);
  assign slot_free  = (state_q == ARB_IDLE) || completing;

  cpu_arb_pick u_pick (
    .inst_req   (inst_req_g),
    .data_req   (data_req_g),
    .slot_free  (slot_free),
    .starve_hit (starve_q == STARVE_LIM),
    .gnt_inst   (gnt_inst),
    .gnt_data   (gnt_data)
  );

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;

    if (state_q == ARB_BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (completing) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
    end

    // A grant overrides the completion bookkeeping above.
    if (gnt_inst || gnt_data) begin
      state_d = ARB_BUSY;
      owner_d = gnt_data ? OWN_DATA : OWN_INST;
      cnt_d   = LAT_CNT;
    end

    // Starvation only accumulates while fetch is actually waiting; any
    // cycle without a fetch request, or a fetch grant, clears it.
    if (!inst_req_g || gnt_inst) begin
      starve_d = '0;
    end else if (gnt_data) begin
      starve_d = sat_inc(starve_q, STARVE_LIM);
    end
  end

  // ---------------------------------------------------------------------
  // Request side: acceptance and SRAM command
  // ---------------------------------------------------------------------
  always_comb begin
    bus.inst_addr_ok = gnt_inst;
    bus.data_addr_ok = gnt_data;
    bus.mem_en       = gnt_inst | gnt_data;
    bus.mem_we       = 4'b0000;
    bus.mem_addr     = 32'h0;
    bus.mem_wdata    = 32'h0;
    if (gnt_data) begin
      bus.mem_we    = bus.data_wr ? bus.data_wstrb : 4'b0000;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end else if (gnt_inst) begin
      bus.mem_addr  = bus.inst_addr;
    end
  end

  // ---------------------------------------------------------------------
  // Response side: decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    bus.inst_data_ok = completing && (owner_q == OWN_INST);
    bus.data_data_ok = completing && (owner_q == OWN_DATA);
    bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : 32'h0;
    bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : 32'h0;
  end

  assign dbg_state      = state_q;
  assign dbg_owner      = owner_q;
  assign dbg_cnt        = cnt_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
`timescale 1ns/1ps
// tb_cpu_sram_arbiter
//   Two arbiter instances (MEM_LAT=1 and MEM_LAT=3), each with its own
//   interface, SRAM model, driver, reference model and response monitor.
module tb_cpu_sram_arbiter;
  import cpu_bus_pkg::*;

  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [7:0]  gap;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // side: 0 = fetch, 1 = data
  typedef struct packed {
    logic        side;
    logic [31:0] rdata;
    logic [31:0] due;
  } exp_t;

  // ---------------------------------------------------------------------
  // Clock / reset-independent bookkeeping
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h required %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h5a5a_0000 ^ (32'(i) * 32'h0100_0193);
  endfunction

  function automatic req_t mk_fetch(input logic [31:0] addr, input int gap);
    req_t r;
    r = '0;
    r.addr = addr;
    r.gap  = 8'(gap);
    return r;
  endfunction

  function automatic req_t mk_data(input logic wr, input logic [3:0] strb,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input int gap);
    req_t r;
    r.wr    = wr;
    r.strb  = strb;
    r.addr  = addr;
    r.wdata = wdata;
    r.gap   = 8'(gap);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    cpu_sram_arbiter_if bus();
    logic                rst_n = 1'b0;
    arb_state_e          dbg_state;
    owner_e              dbg_owner;
    logic [CNT_W-1:0]    dbg_cnt;
    logic [STARVE_W-1:0] dbg_starve_cnt;
    bit                  done_l = 1'b0;

    cpu_sram_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .MEM_LAT      (LAT)
    ) u_dut (
      .clk            (clk),
      .resetn         (rst_n),
      .bus            (bus.slave),
      .dbg_state      (dbg_state),
      .dbg_owner      (dbg_owner),
      .dbg_cnt        (dbg_cnt),
      .dbg_starve_cnt (dbg_starve_cnt)
    );

    // -------------------------------------------------------------------
    // SRAM model: read data appears LAT cycles after mem_en, old contents
    // are read before a write lands.
    // -------------------------------------------------------------------
    logic [31:0] sram    [64];
    logic [31:0] rd_pipe [MEM_LAT_MAX];
    bit          sram_init = 1'b0;

    always @(posedge clk) begin
      if (!sram_init) begin
        for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
        for (int k = 0; k < MEM_LAT_MAX; k++) rd_pipe[k] <= $urandom;
        sram_init <= 1'b1;
      end else begin
        rd_pipe[0] <= bus.mem_en ? sram[bus.mem_addr[7:2]] : $urandom;
        for (int k = 1; k < MEM_LAT_MAX; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (bus.mem_en) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) sram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // -------------------------------------------------------------------
    // Stimulus queues and driver
    // -------------------------------------------------------------------
    req_t iq[$];
    req_t dq[$];
    exp_t exp_q[$];

    initial begin : drv
      bit i_on, d_on, acc_i, acc_d;
      int i_wait, d_wait;
      i_on = 0; d_on = 0; i_wait = 0; d_wait = 0;
      bus.inst_req   = 1'b0;
      bus.inst_addr  = 32'h0;
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_wstrb = 4'h0;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 32'h0;
      forever begin
        @(negedge clk);
        acc_i = bus.inst_addr_ok;
        acc_d = bus.data_addr_ok;
        @(posedge clk);
        #1;
        if (i_on && acc_i) begin void'(iq.pop_front()); i_on = 0; i_wait = 0; end
        if (d_on && acc_d) begin void'(dq.pop_front()); d_on = 0; d_wait = 0; end
        if (!i_on && iq.size() > 0) begin
          if (i_wait >= int'(iq[0].gap)) i_on = 1; else i_wait++;
        end
        if (!d_on && dq.size() > 0) begin
          if (d_wait >= int'(dq[0].gap)) d_on = 1; else d_wait++;
        end
        bus.inst_req   = i_on;
        bus.inst_addr  = i_on ? iq[0].addr : $urandom;
        bus.data_req   = d_on;
        bus.data_wr    = d_on ? dq[0].wr : 1'($urandom);
        bus.data_wstrb = d_on ? dq[0].strb : 4'($urandom);
        bus.data_addr  = d_on ? dq[0].addr : $urandom;
        bus.data_wdata = d_on ? dq[0].wdata : $urandom;
      end
    end

    // -------------------------------------------------------------------
    // Reference model: one access at a time, a new one may start in the
    // cycle the previous one is due; expected responses go to exp_q.
    // -------------------------------------------------------------------
    logic [31:0] ref_mem [64];

    initial begin : model
      int   busy_until;
      int   starve;
      bit   ei, ed, free;
      exp_t e;
      logic [5:0] idx;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      busy_until = -1;
      starve     = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          check($sformatf("L%0d rst addr_ok", LAT), {bus.inst_addr_ok, bus.data_addr_ok}, 0);
          check($sformatf("L%0d rst data_ok", LAT), {bus.inst_data_ok, bus.data_data_ok}, 0);
          check($sformatf("L%0d rst inst_rdata", LAT), bus.inst_rdata, 0);
          check($sformatf("L%0d rst data_rdata", LAT), bus.data_rdata, 0);
          check($sformatf("L%0d rst mem_en/we", LAT), {bus.mem_en, bus.mem_we}, 0);
          check($sformatf("L%0d rst mem_addr", LAT), bus.mem_addr, 0);
          check($sformatf("L%0d rst mem_wdata", LAT), bus.mem_wdata, 0);
          check($sformatf("L%0d rst state/starve", LAT), {dbg_state, dbg_starve_cnt}, 0);
          exp_q.delete();
          busy_until = -1;
          starve     = 0;
        end else begin
          check($sformatf("L%0d busy", LAT), dbg_state == ARB_BUSY, cyc <= busy_until);
          check($sformatf("L%0d starve_cnt", LAT), dbg_starve_cnt, starve);
          free = (cyc >= busy_until);
          ei = 0;
          ed = 0;
          if (free) begin
            if (bus.inst_req && bus.data_req) begin
              if (starve == STARVE_LIMIT) ei = 1; else ed = 1;
            end else begin
              ei = bus.inst_req;
              ed = bus.data_req;
            end
          end
          check($sformatf("L%0d addr_ok", LAT), {bus.inst_addr_ok, bus.data_addr_ok}, {ei, ed});
          check($sformatf("L%0d mem_en", LAT), bus.mem_en, ei | ed);
          if (ed) begin
            idx = bus.data_addr[7:2];
            check($sformatf("L%0d d mem_addr", LAT), bus.mem_addr, bus.data_addr);
            check($sformatf("L%0d d mem_we", LAT), bus.mem_we, bus.data_wr ? bus.data_wstrb : 4'h0);
            check($sformatf("L%0d d mem_wdata", LAT), bus.mem_wdata, bus.data_wdata);
            e.side  = 1'b1;
            e.rdata = ref_mem[idx];
            e.due   = 32'(cyc + LAT);
            exp_q.push_back(e);
            if (bus.data_wr) begin
              for (int b = 0; b < 4; b++)
                if (bus.data_wstrb[b]) ref_mem[idx][8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
          end
          if (ei) begin
            idx = bus.inst_addr[7:2];
            check($sformatf("L%0d i mem_addr", LAT), bus.mem_addr, bus.inst_addr);
            check($sformatf("L%0d i mem_we/wdata", LAT), {28'h0, bus.mem_we} | bus.mem_wdata, 0);
            e.side  = 1'b0;
            e.rdata = ref_mem[idx];
            e.due   = 32'(cyc + LAT);
            exp_q.push_back(e);
          end
          if (ei || ed) busy_until = cyc + LAT;
          if (!bus.inst_req || ei) starve = 0;
          else if (ed && starve < STARVE_LIMIT) starve = starve + 1;
        end
      end
    end

    // -------------------------------------------------------------------
    // Response monitor
    // -------------------------------------------------------------------
    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
            e = exp_q.pop_front();
            check($sformatf("L%0d data_ok", LAT), {bus.inst_data_ok, bus.data_data_ok},
                  e.side ? 2'b01 : 2'b10);
            check($sformatf("L%0d rdata", LAT), e.side ? bus.data_rdata : bus.inst_rdata, e.rdata);
            check($sformatf("L%0d other rdata", LAT), e.side ? bus.inst_rdata : bus.data_rdata, 0);
          end else begin
            check($sformatf("L%0d stray data_ok", LAT), {bus.inst_data_ok, bus.data_data_ok}, 0);
            check($sformatf("L%0d idle rdata", LAT), bus.inst_rdata | bus.data_rdata, 0);
          end
        end
      end
    end

    // -------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------
    task automatic drain();
      int n;
      n = 0;
      while ((iq.size() > 0 || dq.size() > 0 || exp_q.size() > 0) && n < 4000) begin
        @(posedge clk);
        n++;
      end
      if (n >= 4000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL L%0d drain_timeout: %0d requests/responses pending, required 0",
                 LAT, iq.size() + dq.size() + exp_q.size());
      end
      repeat (2) @(posedge clk);
    endtask

    initial begin : seq
      int n;
      int nrand;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #3;

      // single fetch
      iq.push_back(mk_fetch(32'h1c00_0000, 0));
      drain();
      #3;

      // fetch and load together: data first, fetch next
      iq.push_back(mk_fetch(32'h1c00_0004, 0));
      dq.push_back(mk_data(1'b0, 4'h0, 32'h0000_0100, 32'h1234_5678, 0));
      drain();
      #3;

      // partial store, then read it back
      dq.push_back(mk_data(1'b1, 4'b0011, 32'h0000_0108, 32'hdead_beef, 0));
      dq.push_back(mk_data(1'b0, 4'h0, 32'h0000_0108, 32'h0, 0));
      drain();
      #3;

      // starvation: both sides held high
      for (int i = 0; i < 8; i++)
        dq.push_back(mk_data(1'b0, 4'h0, 32'h0000_0200 + 32'(4 * i), 32'h0, 0));
      iq.push_back(mk_fetch(32'h1c00_0040, 0));
      iq.push_back(mk_fetch(32'h1c00_0044, 0));
      drain();
      #3;

      // reset one cycle after a grant drops that access
      if (LAT == 3) begin
        dq.push_back(mk_data(1'b0, 4'h0, 32'h0000_0040, 32'h0, 0));
        iq.push_back(mk_fetch(32'h1c00_0010, 0));
        n = 0;
        while (dq.size() > 0 && n < 100) begin
          @(posedge clk);
          #2;
          n++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
        #3;
      end

      // randomized traffic
      nrand = (LAT == 1) ? 300 : 150;
      for (int i = 0; i < nrand; i++) begin
        iq.push_back(mk_fetch({24'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2'b00},
                              $urandom_range(0, 3)));
        dq.push_back(mk_data(1'($urandom), 4'($urandom_range(1, 15)),
                             {24'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2'b00},
                             $urandom, $urandom_range(0, 3)));
      end
      drain();
      done_l = 1'b1;
    end
  end

  initial begin
    wait (g_inst[0].done_l && g_inst[1].done_l);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Shares one single-port synchronous SRAM between the CPU's instruction-fetch and data-access paths. Each side presents a req/addr_ok/data_ok handshake, and the block arbitrates between them. It issues at most one memory access per cycle and routes each response back to the requester that owns it. It sits between the pipeline's fetch/EX stages and a unified memory. Data has priority, and a starvation guard ensures fetch is still served.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced (1..15)
- MEM_LAT, 1, SRAM read/write completion latency in cycles (1..4)
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch byte address (word aligned)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid this cycle
- inst_rdata  out  32  fetch read data, valid with inst_data_ok
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid this cycle; asserted for stores too
- data_rdata  out  32  load data, valid with data_data_ok
- mem_en  out  1  SRAM enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid MEM_LAT cycles after mem_en

## Operation
- Owner register: NONE / INST / DATA.
  - Holds the side whose access is in flight.
  - A latency counter `cnt` counts from MEM_LAT down to 1.
- FSM states:
  - IDLE: nothing outstanding.
  - BUSY: access outstanding, cnt > 0.
- "Slot free" means the state is IDLE, or the state is BUSY with cnt == 1 (completing this cycle).
- Grant rule, evaluated only when the slot is free:
  - If only one side requests, that side is granted.
  - If both request, data is granted, unless starve_cnt == STARVE_LIMIT, in which case inst is granted.
- Granting a side:
  - Asserts that side's addr_ok combinationally in the same cycle.
  - Drives mem_en=1, mem_addr, and mem_we (data_wstrb when data_wr, else 0).
  - Drives mem_wdata=data_wdata for data grants; mem_wdata is 0 for inst grants.
  - Loads the owner register and sets cnt=MEM_LAT; the state is BUSY on the next cycle.
- Completion, when BUSY and cnt == 1:
  - Asserts the owner's data_ok for one cycle.
  - The owner's rdata equals mem_rdata; the other side's rdata is 0.
  - Moves to IDLE, or straight back to BUSY if a new grant happens in the same cycle (back-to-back).
- starve_cnt (4 bits):
  - Increments on each data grant while inst_req=1 and inst is not granted.
  - Clears on an inst grant or whenever inst_req=0.
  - Saturates at STARVE_LIMIT.
- Requesters hold req and payload stable until addr_ok.
- Dropping req before addr_ok withdraws the request, and the arbiter does not latch it.

## Timing
- Reset (resetn=0, asynchronous):
  - State IDLE, owner NONE, cnt=0, starve_cnt=0.
  - All outputs are 0: addr_ok, data_ok, rdata, mem_en, mem_we, mem_addr, mem_wdata.
- Reset asserted mid-access drops the in-flight access, and no data_ok is produced for it.
- Request-to-response latency: addr_ok in cycle t, data_ok in cycle t+MEM_LAT.
- Throughput:
  - MEM_LAT=1: one access per cycle, fully pipelined.
  - MEM_LAT=N: one access per N cycles.
- Simultaneous completion and new grant in the same cycle: both happen.
  - Responses never overlap, because at most one access is outstanding.
- addr_ok and mem_* are combinational from req and registered state.
- data_ok is decoded from registered state only.
- Never asserted: both addr_ok in one cycle, or both data_ok in one cycle.

## Structure
- Shared package cpu_bus_pkg holds:
  - owner_e {OWN_NONE, OWN_INST, OWN_DATA}
  - arb_state_e {ARB_IDLE, ARB_BUSY}
  - MEM_LAT_MAX=4
- One natural sub-module, cpu_arb_pick: combinational two-way priority select with a starvation override.
  - Inputs: inst_req, data_req, slot_free, starve_hit.
  - Outputs: gnt_inst, gnt_data.

## Test plan
- Reset then a single fetch, MEM_LAT=1: inst_req@0x1c000000 → inst_addr_ok same cycle, mem_en=1, mem_addr=0x1c000000; inst_data_ok next cycle with inst_rdata=mem_rdata.
- Simultaneous inst_req and data_req (load @0x100) → data_addr_ok first; inst_addr_ok the next cycle; data_data_ok and inst_data_ok on consecutive cycles.
- Store with data_wstrb=4'b0011, wdata=0xdeadbeef → mem_we=4'b0011, mem_wdata=0xdeadbeef; data_data_ok 1 cycle later.
- Starvation, STARVE_LIMIT=4: data_req and inst_req both held high → 4 data grants, then 1 inst grant, then data resumes and starve_cnt is back at 0.
- MEM_LAT=3, back-to-back data requests → addr_ok every 3rd cycle; data_ok exactly 3 cycles after each addr_ok.
- resetn pulsed low 1 cycle after a MEM_LAT=3 grant → no data_ok ever appears for that access; all outputs are 0 during reset.
